// File: rtl/mac_st_result_collector_if.sv
// ---------------------------------------------------------------------------
// mac_st_result_collector_if
//
// Purpose: valid/ready result stream leaving the MAC result collector.
//   One beat carries a captured accumulator value plus the tag of the
//   accumulation block it came from.
//
// Signals:
//   res_valid  : head of the result buffer is valid (master -> slave)
//   res_ready  : consumer accepts the head this cycle (slave -> master)
//   res_data   : captured MAC output z, raw bits (master -> slave)
//   res_count  : number of ops in the captured block (master -> slave)
//   res_config : config_aw value at block close (master -> slave)
//
// Modports:
//   master : collector side (drives the stream)
//   slave  : consumer side (drives res_ready)
// ---------------------------------------------------------------------------
interface mac_st_result_collector_if #(
  parameter int Z_WIDTH         = 20,
  parameter int CONFIG_AW_WIDTH = 1
);

  logic                       res_valid;
  logic                       res_ready;
  logic [Z_WIDTH-1:0]         res_data;
  logic [7:0]                 res_count;
  logic [CONFIG_AW_WIDTH-1:0] res_config;

  modport master (
    output res_valid,
    output res_data,
    output res_count,
    output res_config,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_data,
    input  res_count,
    input  res_config,
    output res_ready
  );

endinterface

// File: rtl/mac_st_result_collector.sv
// ---------------------------------------------------------------------------
// mac_st_result_collector
//
// Purpose: captures one signed MAC accumulator result per accumulation
//   block. It mirrors the accu_rst / op-issue sequencing that feeds the MAC,
//   closes a block on an accumulator clear (with ops pending) or when the
//   op count reaches OPS_PER_ACCU, waits out the MAC pipeline latency,
//   samples z and pushes {z, op count, config_aw} into a small
//   first-word-fall-through buffer drained over a valid/ready stream.
//
// Parameters:
//   Z_WIDTH         : width of the MAC output z
//   CONFIG_AW_WIDTH : width of config_aw
//   OPS_PER_ACCU    : op count that auto-closes a block (1..255)
//   MAC_LATENCY     : cycles from op issue to z reflecting that op (>=1)
//   FIFO_DEPTH      : number of buffered results (>=2)
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous reset, active low
//   accu_rst  : accumulator clear cycle (same signal as driven to the MAC)
//   op_valid  : an operand pair is issued to the MAC this cycle
//   config_aw : MAC precision configuration
//   z         : MAC accumulator output (signed, passed through as raw bits)
//   res       : result stream, master modport of mac_st_result_collector_if
//   drop_err  : sticky flag, a result was lost to a full buffer
//   signature : 32-bit rotate/XOR signature of all pushed results
//               (present only with the build option below)
//
// Build option:
//   MAC_ST_COLLECT_SIGNATURE_EN : when defined, adds the signature output.
// ---------------------------------------------------------------------------
module mac_st_result_collector #(
  parameter int Z_WIDTH         = 20,
  parameter int CONFIG_AW_WIDTH = 1,
  parameter int OPS_PER_ACCU    = 50,
  parameter int MAC_LATENCY     = 2,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       accu_rst,
  input  logic                       op_valid,
  input  logic [CONFIG_AW_WIDTH-1:0] config_aw,
  input  logic [Z_WIDTH-1:0]         z,
  mac_st_result_collector_if.master  res,
  output logic                       drop_err
`ifdef MAC_ST_COLLECT_SIGNATURE_EN
  ,
  output logic [31:0]                signature
`endif
);

  localparam int TAG_W = 8 + CONFIG_AW_WIDTH;
  localparam int DLY   = MAC_LATENCY - 1;
  localparam logic [7:0] OPS_MAX = 8'(OPS_PER_ACCU);

  // -------------------------------------------------------------------------
  // Op counter and block-close detection
  // -------------------------------------------------------------------------
  logic [7:0]       cnt_q, cnt_d;
  logic             opTake;
  logic             closeEv;
  logic [TAG_W-1:0] closeTag;

  // A block closes either on a clear with ops pending or one cycle after
  // the op that filled it. Both conditions in the same cycle give a single
  // close. An op issued in an auto-close cycle starts the next block.
  always_comb begin
    opTake   = op_valid && !accu_rst;
    closeEv  = (accu_rst && (cnt_q != 8'd0)) || (cnt_q == OPS_MAX);
    closeTag = {cnt_q, config_aw};
    cnt_d    = cnt_q;
    if (closeEv) begin
      cnt_d = opTake ? 8'd1 : 8'd0;
    end else if (opTake) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Tag delay line: aligns each close with the cycle in which z reflects
  // the last op of the block. One tag per stage, so back-to-back closes
  // each get their own sample.
  // -------------------------------------------------------------------------
  logic             pushVld;
  logic [TAG_W-1:0] pushTag;

  generate
    if (DLY == 0) begin : gNoDly
      assign pushVld = closeEv;
      assign pushTag = closeTag;
    end else begin : gDly
      logic [DLY-1:0]   dlyVld_q;
      logic [TAG_W-1:0] dlyTag_q [DLY];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          dlyVld_q <= '0;
          for (int i = 0; i < DLY; i++) begin
            dlyTag_q[i] <= '0;
          end
        end else begin
          dlyVld_q[0] <= closeEv;
          dlyTag_q[0] <= closeTag;
          for (int i = 1; i < DLY; i++) begin
            dlyVld_q[i] <= dlyVld_q[i-1];
            dlyTag_q[i] <= dlyTag_q[i-1];
          end
        end
      end

      assign pushVld = dlyVld_q[DLY-1];
      assign pushTag = dlyTag_q[DLY-1];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Result buffer: shift-register FIFO whose slot 0 is the head, so the
  // stream outputs come straight from flops. Valid slots are always
  // contiguous from slot 0.
  // -------------------------------------------------------------------------
  logic [FIFO_DEPTH-1:0] fVld_q, fVld_d;
  logic [Z_WIDTH-1:0]    fData_q [FIFO_DEPTH];
  logic [Z_WIDTH-1:0]    fData_d [FIFO_DEPTH];
  logic [TAG_W-1:0]      fTag_q  [FIFO_DEPTH];
  logic [TAG_W-1:0]      fTag_d  [FIFO_DEPTH];
  logic                  pop;
  logic                  full;
  logic                  drop;
  logic                  wrDone;

  // Pop shifts everything down by one first; the push then lands in the
  // first free slot of the shifted image, which lets a full buffer accept
  // a push in the same cycle it pops.
  always_comb begin
    pop     = fVld_q[0] && res.res_ready;
    full    = fVld_q[FIFO_DEPTH-1];
    drop    = pushVld && full && !pop;
    fVld_d  = fVld_q;
    fData_d = fData_q;
    fTag_d  = fTag_q;
    wrDone  = 1'b0;
    if (pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        fVld_d[i]  = fVld_q[i+1];
        fData_d[i] = fData_q[i+1];
        fTag_d[i]  = fTag_q[i+1];
      end
      fVld_d[FIFO_DEPTH-1] = 1'b0;
    end
    if (pushVld && !drop) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (!fVld_d[i] && !wrDone) begin
          fVld_d[i]  = 1'b1;
          fData_d[i] = z;
          fTag_d[i]  = pushTag;
          wrDone     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fVld_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fData_q[i] <= '0;
        fTag_q[i]  <= '0;
      end
    end else begin
      fVld_q  <= fVld_d;
      fData_q <= fData_d;
      fTag_q  <= fTag_d;
    end
  end

  assign res.res_valid  = fVld_q[0];
  assign res.res_data   = fData_q[0];
  assign res.res_count  = fTag_q[0][TAG_W-1 -: 8];
  assign res.res_config = fTag_q[0][CONFIG_AW_WIDTH-1:0];

  // -------------------------------------------------------------------------
  // Sticky drop flag: set whenever a result arrives with nowhere to go.
  // -------------------------------------------------------------------------
  logic dropErr_q, dropErr_d;

  always_comb begin
    dropErr_d = dropErr_q | drop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dropErr_q <= 1'b0;
    end else begin
      dropErr_q <= dropErr_d;
    end
  end

  assign drop_err = dropErr_q;

`ifdef MAC_ST_COLLECT_SIGNATURE_EN
  // -------------------------------------------------------------------------
  // Run signature: folds every pushed z (dropped ones included) into a
  // rotate-left/XOR word so a long run can be checked against one value.
  // -------------------------------------------------------------------------
  logic [31:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (pushVld) begin
      sig_d = {sig_q[30:0], sig_q[31]} ^ 32'(z);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_q <= 32'd0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign signature = sig_q;
`endif

endmodule

// File: tb/tb_mac_st_result_collector.sv
// ---------------------------------------------------------------------------
// tb_mac_st_result_collector
//
// Directed bench for mac_st_result_collector with a stubbed MAC: the bench
// drives z directly in the cycle the collector is expected to sample it.
// Inputs change 1 time unit after each rising edge; outputs are read there.
// ---------------------------------------------------------------------------
module tb_mac_st_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        accu_rst;
  logic        op_valid;
  logic [0:0]  config_aw;
  logic [19:0] z;
  logic        drop_err;
`ifdef MAC_ST_COLLECT_SIGNATURE_EN
  logic [31:0] signature;
`endif

  int compared   = 0;
  int mismatched = 0;

  mac_st_result_collector_if #(.Z_WIDTH(20), .CONFIG_AW_WIDTH(1)) resIf ();

  mac_st_result_collector #(
    .Z_WIDTH        (20),
    .CONFIG_AW_WIDTH(1),
    .OPS_PER_ACCU   (50),
    .MAC_LATENCY    (2),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .accu_rst (accu_rst),
    .op_valid (op_valid),
    .config_aw(config_aw),
    .z        (z),
    .res      (resIf),
    .drop_err (drop_err)
`ifdef MAC_ST_COLLECT_SIGNATURE_EN
    ,
    .signature(signature)
`endif
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  // Advance one cycle and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset for two edges with all inputs idle
  task automatic doReset();
    rst = 1'b0; accu_rst = 1'b0; op_valid = 1'b0; config_aw = 1'b0; z = '0;
    resIf.res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Issue n ops on consecutive cycles
  task automatic issueOps(input int n);
    for (int i = 0; i < n; i++) begin
      op_valid = 1'b1;
      tick();
    end
    op_valid = 1'b0;
  endtask

  // Short block: n ops, clear cycle, then z = value in the sampling cycle
  task automatic shortBlock(input int n, input logic [19:0] value);
    issueOps(n);
    accu_rst = 1'b1;
    tick();
    accu_rst = 1'b0;
    z = value;
    tick();
    z = '0;
  endtask

  task automatic test_reset();
    doReset();
    compared++; if (resIf.res_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %0b want 0", resIf.res_valid); end
    compared++; if (resIf.res_data !== 20'h0) begin mismatched++; $display("[TB] FAIL reset_data: got %h want 00000", resIf.res_data); end
    compared++; if (resIf.res_count !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_count: got %0d want 0", resIf.res_count); end
    compared++; if (resIf.res_config !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_config: got %0b want 0", resIf.res_config); end
    compared++; if (drop_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_drop: got %0b want 0", drop_err); end
`ifdef MAC_ST_COLLECT_SIGNATURE_EN
    compared++; if (signature !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_sig: got %h want 0", signature); end
`endif
  endtask

  task automatic test_full_block();
    // 50 ops; the following cycle is the auto-close cycle c
    issueOps(50);
    z = '0;
    compared++; if (resIf.res_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL full_valid_c: got %0b want 0", resIf.res_valid); end
    tick();
    z = 20'h00123;
    compared++; if (resIf.res_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL full_valid_c1: got %0b want 0", resIf.res_valid); end
    tick();
    z = '0;
    compared++; if (resIf.res_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL full_valid_c2: got %0b want 1", resIf.res_valid); end
    compared++; if (resIf.res_data !== 20'h00123) begin mismatched++; $display("[TB] FAIL full_data: got %h want 00123", resIf.res_data); end
    compared++; if (resIf.res_count !== 8'd50) begin mismatched++; $display("[TB] FAIL full_count: got %0d want 50", resIf.res_count); end
    // Holding ready low must keep the head stable
    tick();
    compared++; if (resIf.res_data !== 20'h00123 || resIf.res_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL full_hold: got %h/%0b want 00123/1", resIf.res_data, resIf.res_valid); end
    resIf.res_ready = 1'b1;
    tick();
    resIf.res_ready = 1'b0;
    compared++; if (resIf.res_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL full_popped: got %0b want 0", resIf.res_valid); end
  endtask

  task automatic test_early_close();
    issueOps(3);
    accu_rst = 1'b1; config_aw = 1'b1;
    tick();
    accu_rst = 1'b0; config_aw = 1'b0; z = 20'hFFFF6;
    tick();
    z = '0;
    compared++; if (resIf.res_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL early_valid: got %0b want 1", resIf.res_valid); end
    compared++; if (resIf.res_count !== 8'd3) begin mismatched++; $display("[TB] FAIL early_count: got %0d want 3", resIf.res_count); end
    compared++; if (resIf.res_config !== 1'b1) begin mismatched++; $display("[TB] FAIL early_config: got %0b want 1", resIf.res_config); end
    compared++; if (resIf.res_data !== 20'hFFFF6) begin mismatched++; $display("[TB] FAIL early_data: got %h want ffff6", resIf.res_data); end
    resIf.res_ready = 1'b1;
    tick();
    resIf.res_ready = 1'b0;
  endtask

  task automatic test_empty_clears();
    accu_rst = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    accu_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      compared++; if (resIf.res_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL empty_valid[%0d]: got %0b want 0", i, resIf.res_valid); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    // Auto-close at c carries an op into the next block; a clear at c+1
    // closes that 1-op block, giving closes on consecutive cycles.
    issueOps(50);
    op_valid = 1'b1; config_aw = 1'b0;
    tick();
    op_valid = 1'b0; accu_rst = 1'b1; config_aw = 1'b1; z = 20'hAAAAA;
    tick();
    accu_rst = 1'b0; config_aw = 1'b0; z = 20'h55555;
    resIf.res_ready = 1'b1;
    compared++; if (resIf.res_valid !== 1'b1 || resIf.res_data !== 20'hAAAAA) begin mismatched++; $display("[TB] FAIL b2b_first_data: got %0b/%h want 1/aaaaa", resIf.res_valid, resIf.res_data); end
    compared++; if (resIf.res_count !== 8'd50 || resIf.res_config !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_first_tag: got %0d/%0b want 50/0", resIf.res_count, resIf.res_config); end
    tick();
    z = '0;
    compared++; if (resIf.res_valid !== 1'b1 || resIf.res_data !== 20'h55555) begin mismatched++; $display("[TB] FAIL b2b_second_data: got %0b/%h want 1/55555", resIf.res_valid, resIf.res_data); end
    compared++; if (resIf.res_count !== 8'd1 || resIf.res_config !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_second_tag: got %0d/%0b want 1/1", resIf.res_count, resIf.res_config); end
    tick();
    resIf.res_ready = 1'b0;
    compared++; if (resIf.res_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_drained: got %0b want 0", resIf.res_valid); end
  endtask

  task automatic test_close_with_accu_rst();
    // Clear in the auto-close cycle is one close; the extra clear is empty
    issueOps(50);
    accu_rst = 1'b1;
    tick();
    z = 20'h00321;
    tick();
    accu_rst = 1'b0; z = '0;
    compared++; if (resIf.res_valid !== 1'b1 || resIf.res_data !== 20'h00321) begin mismatched++; $display("[TB] FAIL coinc_data: got %0b/%h want 1/00321", resIf.res_valid, resIf.res_data); end
    compared++; if (resIf.res_count !== 8'd50) begin mismatched++; $display("[TB] FAIL coinc_count: got %0d want 50", resIf.res_count); end
    resIf.res_ready = 1'b1;
    tick();
    resIf.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      compared++; if (resIf.res_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL coinc_single[%0d]: got %0b want 0", i, resIf.res_valid); end
      tick();
    end
  endtask

  task automatic test_overflow();
    logic [19:0] expData;
    resIf.res_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      expData = 20'(k);
      shortBlock(2, expData);
    end
    compared++; if (drop_err !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_drop: got %0b want 1", drop_err); end
    resIf.res_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      expData = 20'(k);
      compared++; if (resIf.res_valid !== 1'b1 || resIf.res_data !== expData) begin mismatched++; $display("[TB] FAIL ovf_drain[%0d]: got %0b/%h want 1/%h", k, resIf.res_valid, resIf.res_data, expData); end
      compared++; if (resIf.res_count !== 8'd2) begin mismatched++; $display("[TB] FAIL ovf_count[%0d]: got %0d want 2", k, resIf.res_count); end
      tick();
    end
    resIf.res_ready = 1'b0;
    compared++; if (resIf.res_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL ovf_lost5: got %0b want 0", resIf.res_valid); end
    compared++; if (drop_err !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_sticky: got %0b want 1", drop_err); end
  endtask

  task automatic test_mid_reset();
    // Leave one result buffered, then reset with a tag in flight
    shortBlock(1, 20'h00007);
    compared++; if (resIf.res_valid !== 1'b1 || resIf.res_data !== 20'h00007) begin mismatched++; $display("[TB] FAIL mrst_pre: got %0b/%h want 1/00007", resIf.res_valid, resIf.res_data); end
    issueOps(10);
    accu_rst = 1'b1;
    tick();
    accu_rst = 1'b0; z = 20'h00055;
    #2;
    rst = 1'b0;
    #1;
    compared++; if (resIf.res_valid !== 1'b0 || resIf.res_data !== 20'h0) begin mismatched++; $display("[TB] FAIL mrst_out: got %0b/%h want 0/00000", resIf.res_valid, resIf.res_data); end
    compared++; if (resIf.res_count !== 8'd0 || resIf.res_config !== 1'b0) begin mismatched++; $display("[TB] FAIL mrst_tag: got %0d/%0b want 0/0", resIf.res_count, resIf.res_config); end
    compared++; if (drop_err !== 1'b0) begin mismatched++; $display("[TB] FAIL mrst_drop: got %0b want 0", drop_err); end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++; if (resIf.res_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mrst_lost[%0d]: got %0b want 0", i, resIf.res_valid); end
    end
    z = '0;
    shortBlock(2, 20'h00009);
    compared++; if (resIf.res_valid !== 1'b1 || resIf.res_data !== 20'h00009) begin mismatched++; $display("[TB] FAIL mrst_next_data: got %0b/%h want 1/00009", resIf.res_valid, resIf.res_data); end
    compared++; if (resIf.res_count !== 8'd2) begin mismatched++; $display("[TB] FAIL mrst_next_count: got %0d want 2", resIf.res_count); end
    resIf.res_ready = 1'b1;
    tick();
    resIf.res_ready = 1'b0;
  endtask

`ifdef MAC_ST_COLLECT_SIGNATURE_EN
  task automatic test_signature();
    doReset();
    shortBlock(1, 20'h00001);
    compared++; if (signature !== 32'h1) begin mismatched++; $display("[TB] FAIL sig_first: got %h want 00000001", signature); end
    resIf.res_ready = 1'b1;
    tick();
    resIf.res_ready = 1'b0;
    shortBlock(1, 20'h00002);
    compared++; if (signature !== 32'h0) begin mismatched++; $display("[TB] FAIL sig_second: got %h want 00000000", signature); end
    resIf.res_ready = 1'b1;
    tick();
    resIf.res_ready = 1'b0;
  endtask
`endif

  initial begin
    $display("[TB] start");
    test_reset();
`ifdef MAC_ST_COLLECT_SIGNATURE_EN
    test_signature();
`endif
    test_full_block();
    test_early_close();
    test_empty_clears();
    test_back_to_back();
    test_close_with_accu_rst();
    test_overflow();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mac_st_result_collector.md
# mac_st_result_collector

Synthesizable result-capture unit at the output side of `top_mac_st`. It watches the same `accu_rst` / operand-issue sequencing that feeds the MAC. It samples the signed accumulator output `z` once per accumulation block, after the MAC pipeline latency. Each captured result is tagged with the block's op count and `config_aw`, buffered in a small FIFO and handed off on a valid/ready stream, so on-chip and post-silicon runs can read back MAC results without a testbench monitor.

## Interface
- `Z_WIDTH`, 20, width of MAC output `z` (W_WIDTH+A_WIDTH+PLUS_WIDTH).
- `CONFIG_AW_WIDTH`, 1, width of `config_aw`.
- `OPS_PER_ACCU`, 50, maximum ops per block; reaching it auto-closes the block (1..255).
- `MAC_LATENCY`, 2, cycles from an op-issue cycle to `z` reflecting that op (>=1).
- `FIFO_DEPTH`, 4, result entries (power of two, >=2).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `accu_rst` in 1: same signal driven to the MAC; high = accumulator clear cycle.
- `op_valid` in 1: an operand pair is issued to the MAC this cycle (ignored while `accu_rst`=1).
- `config_aw` in CONFIG_AW_WIDTH: MAC precision config.
- `z` in Z_WIDTH: MAC accumulator output, signed.
- `res_valid` out 1: FIFO head valid.
- `res_ready` in 1: consumer accepts head.
- `res_data` out Z_WIDTH: captured `z`.
- `res_count` out 8: ops in the captured block (1..OPS_PER_ACCU).
- `res_config` out CONFIG_AW_WIDTH: `config_aw` at close.
- `drop_err` out 1: sticky; a result was lost to a full FIFO.

## Operation
- Op counter `cnt` (8 bit): +1 on each cycle with `op_valid`=1 and `accu_rst`=0.
- Block close event, evaluated every cycle:
  - (a) `accu_rst`=1 and `cnt`>0; or
  - (b) the cycle after the op that made `cnt`==OPS_PER_ACCU.
  - On close: latch {`cnt`, `config_aw`} into a tag, launch it into a MAC_LATENCY-1-stage delay line (0 stages when MAC_LATENCY=1), and clear `cnt`. Case (a) clears on the `accu_rst` edge.
  - Case (b) with `op_valid` in the close cycle: that op counts as 1 in the new block.
  - A close on the same cycle as `accu_rst` is a single close; no double push.
- `accu_rst`=1 with `cnt`==0 produces no result, including back-to-back clears.
- When a tag exits the delay line, `z` is sampled that cycle and {`z`, tag} is pushed to the FIFO.
- FIFO is first-word-fall-through.
  - Pop on `res_valid`&&`res_ready`.
  - Push while full and not popping: entry discarded, `drop_err` set until reset.
  - Push and pop in the same cycle while full: both succeed.
- `res_data` passes `z` bits unchanged. No sign extension and no saturation.
- Mid-operation `rst` low: counter, delay line and FIFO are flushed; in-flight results are lost.

## Timing
- Reset values: `res_valid`=0, `res_data`=0, `res_count`=0, `res_config`=0, `drop_err`=0; signature output 0.
- Close on cycle c -> `z` sampled at cycle c+MAC_LATENCY-1 -> `res_valid`=1 from cycle c+MAC_LATENCY.
- Closes can occur on consecutive cycles. The delay line holds overlapping tags, one per stage, for sustained one-result-per-cycle throughput.
- `res_data`/`res_count`/`res_config` are stable while `res_valid`=1 and `res_ready`=0.
- All outputs are registered.

## Configuration
- `MAC_ST_COLLECT_SIGNATURE_EN` defined:
  - Adds output `signature` (32 bit), reset 0.
  - On every FIFO push (including dropped pushes), `signature` <= {`signature`[30:0], `signature`[31]} ^ zero-extended `res_data`.
  - Used for single-word pass/fail comparison of long runs.
- Not defined: port and logic are absent. All other behaviour is identical.

## Test plan
- Stub MAC, MAC_LATENCY=2. Issue 50 ops; `z` becomes 20'h00123 at close+1. Expected: one result, `res_data`=20'h00123, `res_count`=50, `res_valid` rises 2 cycles after close.
- `accu_rst` after 3 ops, `config_aw`=1, `z`=20'hFFFF6 (-10). Expected: `res_count`=3, `res_config`=1, `res_data`=20'hFFFF6.
- Five consecutive `accu_rst` cycles with no ops. Expected: `res_valid` stays 0 and no push occurs.
- `res_ready`=0, five 2-op blocks with z=1..5, FIFO_DEPTH=4. Expected: `drop_err`=1. Releasing `res_ready` drains 1,2,3,4 in order; 5 is lost.
- Assert `rst` low mid-block, after 10 ops with a close tag in flight. Expected: all outputs 0 immediately; no result after release. The next 2-op block reports `res_count`=2.
- With MAC_ST_COLLECT_SIGNATURE_EN, push results 1 then 2. Expected: `signature`=32'h1, then 32'h0 ({0,1} rotated = 2, XOR 2 = 0).
